// File: rtl/except_seq.sv
// -----------------------------------------------------------------------------
// except_seq -- exception / ERET redirect sequencer for the NaiveMIPS datapath.
//
// Accepts the single-cycle exception (or ERET) request raised by the MM-stage
// exception unit and latches its target PC. While outstanding instruction and
// data bus transactions drain, it holds the whole pipeline. It then flushes
// every pipeline register for FLUSH_CYCLES cycles and hands the target PC to
// fetch over a valid/ready handshake. cp0_commit gates the CP0 write enable so
// that a stalled MM stage commits its CP0 update exactly once.
//
// Parameters:
//   FLUSH_CYCLES  cycles flush is held high (1..15)
//   TIMEOUT       max DRAIN cycles before a forced proceed (1..65535);
//                 only meaningful when EXCEPT_SEQ_TIMEOUT_EN is defined
//
// Optional feature macro:
//   EXCEPT_SEQ_TIMEOUT_EN  compiles in the drain watchdog counter and the
//                          sticky drain_timeout flag. When undefined, DRAIN
//                          waits indefinitely and drain_timeout is tied to 0.
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   except          in   exception / ERET request (single cycle)
//   except_addr     in   [31:0] target PC (handler vector or EPC)
//   ibus_busy       in   instruction bus transaction outstanding
//   dbus_busy       in   data bus transaction outstanding
//   redirect_ready  in   fetch accepts the redirect
//   cp0_commit      out  CP0 write gate, combinational (except & IDLE)
//   stall_all       out  freeze every pipeline register
//   flush           out  clear every pipeline register to a bubble
//   redirect_valid  out  redirect_addr is valid
//   redirect_addr   out  [31:0] latched target PC
//   busy            out  sequencer is not IDLE
//   drain_timeout   out  sticky: a drain was forcibly abandoned
// -----------------------------------------------------------------------------
module except_seq #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        except,
  input  logic [31:0] except_addr,
  input  logic        ibus_busy,
  input  logic        dbus_busy,
  input  logic        redirect_ready,
  output logic        cp0_commit,
  output logic        stall_all,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_addr,
  output logic        busy,
  output logic        drain_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_REDIR = 2'd3
  } state_e;

  // An out-of-range configuration degrades to a single-cycle flush rather
  // than loading a wrapped count into the 4-bit flush counter.
  localparam bit CFG_LEGAL = (FLUSH_CYCLES >= 1) && (FLUSH_CYCLES <= 15) &&
                             (TIMEOUT >= 1) && (TIMEOUT <= 65535);
  localparam logic [3:0] FLUSH_LOAD = CFG_LEGAL ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic        bus_busy;

  assign bus_busy = ibus_busy | dbus_busy;

`ifdef EXCEPT_SEQ_TIMEOUT_EN
  localparam int unsigned DCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(TIMEOUT);

  logic [DCNT_W-1:0] dcnt_q, dcnt_d, dcnt_inc;
  logic              dto_q, dto_d;

  // Saturating increment: the counter parks at TIMEOUT instead of wrapping.
  assign dcnt_inc = (dcnt_q == DCNT_MAX) ? dcnt_q : dcnt_q + 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    fcnt_d   = fcnt_q;
`ifdef EXCEPT_SEQ_TIMEOUT_EN
    dcnt_d   = dcnt_q;
    dto_d    = dto_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (except) begin
          target_d = except_addr;
          if (bus_busy) begin
            state_d = S_DRAIN;
`ifdef EXCEPT_SEQ_TIMEOUT_EN
            dcnt_d  = '0;
`endif
          end else begin
            state_d = S_FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end
        end
      end

      S_DRAIN: begin
        if (!bus_busy) begin
          state_d = S_FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end else begin
`ifdef EXCEPT_SEQ_TIMEOUT_EN
          // The counter reaching TIMEOUT at the end of this cycle means this
          // was the TIMEOUT-th drain cycle: give up on the bus and proceed.
          dcnt_d = dcnt_inc;
          if (dcnt_inc == DCNT_MAX) begin
            state_d = S_FLUSH;
            fcnt_d  = FLUSH_LOAD;
            dto_d   = 1'b1;
          end
`endif
        end
      end

      S_FLUSH: begin
        if (fcnt_q == 4'd0) begin
          state_d = S_REDIR;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end

      S_REDIR: begin
        // redirect_valid is constant-high in this state, so the handshake
        // reduces to redirect_ready alone.
        if (redirect_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      fcnt_q   <= fcnt_d;
    end
  end

`ifdef EXCEPT_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q <= '0;
      dto_q  <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      dto_q  <= dto_d;
    end
  end

  assign drain_timeout = dto_q;
`else
  assign drain_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registered state except the CP0 gate, which
  // must be visible in the acceptance cycle itself.
  // ---------------------------------------------------------------------------
  assign cp0_commit     = except & (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign stall_all      = (state_q != S_IDLE);
  assign flush          = (state_q == S_FLUSH);
  assign redirect_valid = (state_q == S_REDIR);
  assign redirect_addr  = target_q;

endmodule

// File: tb/tb_except_seq.sv
module tb_except_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exc = 1'b0;
  logic [31:0] addr = '0;
  logic        ibus = 1'b0;
  logic        dbus = 1'b0;
  logic        rdy = 1'b1;

  // u0: FLUSH_CYCLES=1, TIMEOUT=4
  logic        cp0_0, stall_0, flush_0, rv_0, busy_0, dto_0;
  logic [31:0] ra_0;
  // u1: FLUSH_CYCLES=3
  logic        cp0_1, stall_1, flush_1, rv_1, busy_1, dto_1;
  logic [31:0] ra_1;
  // u2: FLUSH_CYCLES=15
  logic        cp0_2, stall_2, flush_2, rv_2, busy_2, dto_2;
  logic [31:0] ra_2;

  except_seq #(.FLUSH_CYCLES(1), .TIMEOUT(4)) u0 (
    .clk(clk), .rst_n(rst_n), .except(exc), .except_addr(addr),
    .ibus_busy(ibus), .dbus_busy(dbus), .redirect_ready(rdy),
    .cp0_commit(cp0_0), .stall_all(stall_0), .flush(flush_0),
    .redirect_valid(rv_0), .redirect_addr(ra_0), .busy(busy_0),
    .drain_timeout(dto_0));

  except_seq #(.FLUSH_CYCLES(3), .TIMEOUT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .except(exc), .except_addr(addr),
    .ibus_busy(ibus), .dbus_busy(dbus), .redirect_ready(rdy),
    .cp0_commit(cp0_1), .stall_all(stall_1), .flush(flush_1),
    .redirect_valid(rv_1), .redirect_addr(ra_1), .busy(busy_1),
    .drain_timeout(dto_1));

  except_seq #(.FLUSH_CYCLES(15), .TIMEOUT(4)) u2 (
    .clk(clk), .rst_n(rst_n), .except(exc), .except_addr(addr),
    .ibus_busy(ibus), .dbus_busy(dbus), .redirect_ready(rdy),
    .cp0_commit(cp0_2), .stall_all(stall_2), .flush(flush_2),
    .redirect_valid(rv_2), .redirect_addr(ra_2), .busy(busy_2),
    .drain_timeout(dto_2));

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cp0cnt = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every redirect handshake on u0 must deliver the oldest
  // expected target pushed when the request was driven.
  always @(negedge clk) begin
    if (mon_en && rv_0 && rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow observed=%h expected=none", ra_0);
      end else begin
        chk32("sb_redirect_addr", ra_0, exp_q.pop_front());
      end
    end
  end

  initial begin
    int fl_n, fl_first, fl_last;
    bit rv_seen;

    // Reset state
    #2;
    chk1("rst_cp0", cp0_0, 1'b0);
    chk1("rst_stall", stall_0, 1'b0);
    chk1("rst_flush", flush_0, 1'b0);
    chk1("rst_rv", rv_0, 1'b0);
    chk32("rst_ra", ra_0, 32'h0);
    chk1("rst_busy", busy_0, 1'b0);
    chk1("rst_dto", dto_0, 1'b0);
    cyc();
    rst_n = 1'b1;
    mon_en = 1'b1;
    cyc();

    // Basic redirect
    exc = 1'b1; addr = 32'hbfc00380; rdy = 1'b1; exp_q.push_back(32'hbfc00380);
    @(negedge clk);
    chk1("basic_c0_cp0", cp0_0, 1'b1);
    chk1("basic_c0_flush", flush_0, 1'b0);
    cyc(); exc = 1'b0; addr = 32'h0;
    @(negedge clk);
    chk1("basic_c1_flush", flush_0, 1'b1);
    chk1("basic_c1_stall", stall_0, 1'b1);
    chk1("basic_c1_cp0", cp0_0, 1'b0);
    cyc();
    @(negedge clk);
    chk1("basic_c2_rv", rv_0, 1'b1);
    chk32("basic_c2_ra", ra_0, 32'hbfc00380);
    chk1("basic_c2_flush", flush_0, 1'b0);
    cyc();
    @(negedge clk);
    chk1("basic_c3_busy", busy_0, 1'b0);
    chk1("basic_c3_rv", rv_0, 1'b0);

    // Drain: dbus busy at acceptance and for two more cycles -> 3 DRAIN cycles
    cyc(); exc = 1'b1; dbus = 1'b1; addr = 32'h80000180; exp_q.push_back(32'h80000180);
    @(negedge clk);
    chk1("drain_cp0", cp0_0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(); exc = 1'b0;
      if (i == 2) dbus = 1'b0;
      @(negedge clk);
      chk1("drain_stall", stall_0, 1'b1);
      chk1("drain_noflush", flush_0, 1'b0);
      chk1("drain_norv", rv_0, 1'b0);
    end
    cyc();
    @(negedge clk);
    chk1("drain_flush", flush_0, 1'b1);
    cyc();
    @(negedge clk);
    chk1("drain_rv", rv_0, 1'b1);
    cyc();
    @(negedge clk);
    chk1("drain_idle", busy_0, 1'b0);
    chk1("drain_dto", dto_0, 1'b0);

    // Backpressure with except held high
    cyc(); rdy = 1'b0; exc = 1'b1; addr = 32'hbfc00200; exp_q.push_back(32'hbfc00200);
    cp0cnt = 0;
    @(negedge clk);
    cp0cnt += int'(cp0_0);
    chk1("bp_cp0_first", cp0_0, 1'b1);
    cyc(); addr = 32'h8000_0000;
    @(negedge clk);
    cp0cnt += int'(cp0_0);
    chk1("bp_flush", flush_0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      cp0cnt += int'(cp0_0);
      chk1("bp_rv_hold", rv_0, 1'b1);
      chk32("bp_ra_hold", ra_0, 32'hbfc00200);
    end
    cyc(); rdy = 1'b1;
    @(negedge clk);
    cp0cnt += int'(cp0_0);
    chk1("bp_handshake_rv", rv_0, 1'b1);
    chk1("bp_handshake_nocp0", cp0_0, 1'b0);
    cyc(); exc = 1'b0;
    @(negedge clk);
    chk1("bp_idle", busy_0, 1'b0);
    chk32("bp_cp0_once", 32'(cp0cnt), 32'd1);

    // Timeout: ibus stuck high
    cyc(); ibus = 1'b1; exc = 1'b1; addr = 32'hbfc00380; exp_q.push_back(32'hbfc00380);
    @(negedge clk);
    chk1("to_cp0", cp0_0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(); exc = 1'b0;
      @(negedge clk);
      chk1("to_drain_stall", stall_0, 1'b1);
      chk1("to_drain_noflush", flush_0, 1'b0);
    end
`ifdef EXCEPT_SEQ_TIMEOUT_EN
    cyc();
    @(negedge clk);
    chk1("to_forced_flush", flush_0, 1'b1);
    chk1("to_dto_set", dto_0, 1'b1);
    cyc();
    @(negedge clk);
    chk1("to_rv", rv_0, 1'b1);
    cyc();
    @(negedge clk);
    chk1("to_idle", busy_0, 1'b0);
    chk1("to_dto_sticky", dto_0, 1'b1);
    cyc(); ibus = 1'b0;
`else
    for (int i = 0; i < 96; i++) begin
      cyc();
      @(negedge clk);
      chk1("nto_stay_drain", flush_0 | rv_0 | ~busy_0, 1'b0);
    end
    chk1("nto_dto_zero", dto_0, 1'b0);
    cyc(); ibus = 1'b0;
    @(negedge clk);
    chk1("nto_still_drain", flush_0, 1'b0);
    cyc();
    @(negedge clk);
    chk1("nto_flush", flush_0, 1'b1);
    cyc();
    @(negedge clk);
    chk1("nto_rv", rv_0, 1'b1);
    cyc();
`endif
    @(negedge clk);
    chk32("sb_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    // Reset mid-FLUSH on u1 (FLUSH_CYCLES=3)
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    chk1("rst2_dto_clear", dto_0, 1'b0);
    cyc(); exc = 1'b1; addr = 32'hbfc00380; rdy = 1'b1;
    cyc(); exc = 1'b0;
    @(negedge clk);
    chk1("mf_flush1", flush_1, 1'b1);
    cyc();
    #1;
    chk1("mf_flush2", flush_1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mf_rst_flush", flush_1, 1'b0);
    chk1("mf_rst_stall", stall_1, 1'b0);
    chk1("mf_rst_busy", busy_1, 1'b0);
    chk1("mf_rst_rv", rv_1, 1'b0);
    chk32("mf_rst_ra", ra_1, 32'h0);
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("mf_no_redirect", rv_1 | busy_1, 1'b0);
      cyc();
    end

    // Flush length on u2 (FLUSH_CYCLES=15)
    exc = 1'b1; addr = 32'h80000000; rdy = 1'b1;
    @(negedge clk);
    chk1("fl_cp0", cp0_2, 1'b1);
    fl_n = 0; fl_first = -1; fl_last = -1; rv_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(); exc = 1'b0;
      @(negedge clk);
      if (flush_2) begin
        fl_n++;
        if (fl_first < 0) fl_first = i;
        fl_last = i;
      end
      if (rv_2) rv_seen = 1'b1;
    end
    chk32("fl_count", 32'(fl_n), 32'd15);
    chk32("fl_start", 32'(fl_first), 32'd0);
    chk32("fl_contiguous", 32'(fl_last - fl_first + 1), 32'd15);
    chk1("fl_redirect_seen", rv_seen, 1'b1);
    chk1("fl_back_idle", busy_2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/except_seq.md
# except_seq

Exception/ERET redirect sequencer for the NaiveMIPS datapath. It accepts the single-cycle exception request from the MM-stage exception unit and latches the target address. It then holds the pipeline while outstanding instruction and data bus transactions drain, flushes all pipeline registers, and hands the target PC to fetch through a valid/ready handshake. It also generates the one-shot CP0 commit strobe, so a stalled MM stage cannot write CP0 twice.

## Interface
- `FLUSH_CYCLES`, default 1: cycles `flush` is held high; legal range 1–15.
- `TIMEOUT`, default 255: maximum drain cycles before a forced proceed; used only with `EXCEPT_SEQ_TIMEOUT_EN`; legal range 1–65535.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `except`  in  1  exception or ERET request from the MM exception unit.
- `except_addr`  in  32  target PC: handler vector or EPC.
- `ibus_busy`  in  1  instruction bus has an outstanding transaction.
- `dbus_busy`  in  1  data bus has an outstanding transaction.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `cp0_commit`  out  1  CP0 write enable gate; combinational.
- `stall_all`  out  1  freeze every pipeline register.
- `flush`  out  1  clear every pipeline register to a bubble.
- `redirect_valid`  out  1  `redirect_addr` is valid.
- `redirect_addr`  out  32  latched target PC.
- `busy`  out  1  sequencer is not in IDLE.
- `drain_timeout`  out  1  sticky; a drain was forcibly abandoned.

## Operation
- **States:** IDLE, DRAIN, FLUSH, REDIR; 2-bit encoding.
- **IDLE:**
  - On `except=1`, latch `except_addr` into `target`.
  - If `ibus_busy|dbus_busy`, go to DRAIN; otherwise go to FLUSH.
  - `cp0_commit = except & (state==IDLE)`, so it is high for exactly the acceptance cycle.
- **DRAIN:**
  - When both busy inputs are low, go to FLUSH.
  - With the timeout feature, a drain counter increments each DRAIN cycle. On reaching `TIMEOUT`, go to FLUSH and set `drain_timeout`.
- **FLUSH:**
  - `flush=1`.
  - A counter loaded with `FLUSH_CYCLES-1` on entry decrements each cycle. When it is zero, go to REDIR.
- **REDIR:**
  - `redirect_valid=1` and `redirect_addr=target`.
  - On `redirect_valid & redirect_ready`, go to IDLE.
- **Stall:** `stall_all = (state!=IDLE)`. `flush` and `stall_all` are both high in FLUSH, and flush takes precedence in the pipeline registers.
- **Requests while busy:** `except` is ignored in every state other than IDLE. No queueing; a second request is dropped.
- **Back-to-back requests:** `except` high in the same cycle REDIR hands off is not accepted. It is accepted on the following IDLE cycle if still asserted.
- **`redirect_addr` outside REDIR:** holds `target`, but it is qualified only by `redirect_valid`.
- **Counter widths:** the drain counter is `$clog2(TIMEOUT+1)` bits and saturates, never wrapping. The flush counter is 4 bits.

## Timing
- **Reset:**
  - `rst_n` low forces the following immediately (asynchronously): state IDLE, `target=0`, both counters 0, `drain_timeout=0`.
  - All registered outputs go to 0.
  - `cp0_commit` is 0 whenever `except` is 0.
  - Reset mid-sequence abandons the sequence with no redirect.
- **Latency, no drain, `FLUSH_CYCLES=1`, `redirect_ready` tied high:**
  - Cycle 0: accept, `cp0_commit`.
  - Cycle 1: `flush`.
  - Cycle 2: `redirect_valid` and handshake.
  - Cycle 3: IDLE.
- **Drain cost:** each drain cycle adds one cycle. Busy inputs are sampled every cycle.
- **`redirect_valid`:** once high, it stays high with `redirect_addr` stable until the handshake completes. It must not depend combinationally on `redirect_ready`.
- **`drain_timeout`:** clears only on reset.

## Configuration
- **`EXCEPT_SEQ_TIMEOUT_EN` defined:** the drain counter, `TIMEOUT` handling and `drain_timeout` logic are compiled in.
- **Not defined:**
  - DRAIN waits indefinitely for both busy inputs to fall.
  - The drain counter is absent.
  - `drain_timeout` is tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- **Basic redirect:** `except=1` for 1 cycle with `except_addr=32'hbfc00380`, busy low, ready high → `cp0_commit` in cycle 0, `flush` in cycle 1, `redirect_valid` with `32'hbfc00380` in cycle 2, `busy=0` in cycle 3.
- **Drain:** `dbus_busy` high for 3 cycles after accept → 3 DRAIN cycles with `stall_all=1` and `flush=0`, then FLUSH, then REDIR; `drain_timeout=0`.
- **Backpressure and request suppression:** `redirect_ready` low for 4 REDIR cycles while `except` is held high with `32'h8000_0000` → `redirect_addr` stays at the first target, `cp0_commit` pulses exactly once, and IDLE follows the handshake.
- **Timeout:** `TIMEOUT=4`, with `EXCEPT_SEQ_TIMEOUT_EN`, `ibus_busy` stuck high → FLUSH entered after 4 DRAIN cycles and `drain_timeout=1` stays set. Without the macro, the sequencer remains in DRAIN for 100 cycles.
- **Reset mid-FLUSH:** `FLUSH_CYCLES=3`, `rst_n` low in the 2nd flush cycle → outputs are 0 immediately and there is no `redirect_valid` after release.
- **Flush length:** `FLUSH_CYCLES=15` → `flush` is high for exactly 15 consecutive cycles.
